// File: rtl/bin_to_disp_digits.sv
// Serial double-dabble binary-to-display-code converter for an 8-digit scan driver.
// Codes 0-9 are digits, 10 is blank and 11 is a dash. Outputs change only on the cycle that raises done.
module bin_to_disp_digits #(
    parameter int DATA_W   = 27,
    parameter bit SIGNED   = 1'b0,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        bit_7,
    output logic [3:0]        bit_6,
    output logic [3:0]        bit_5,
    output logic [3:0]        bit_4,
    output logic [3:0]        bit_3,
    output logic [3:0]        bit_2,
    output logic [3:0]        bit_1,
    output logic [3:0]        bit_0
);
    localparam int         CNT_W      = $clog2(DATA_W);
    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;
    localparam logic [3:0] LEAD_RST   = BLANK_LZ ? CODE_BLANK : 4'd0;
    localparam logic [31:0] DISP_RST  = {{7{LEAD_RST}}, 4'd0};

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] mag_reg;
    logic [31:0]       bcd_reg;
    logic              neg_reg;
    logic              ovf_reg;
    logic              done_reg;
    logic [31:0]       disp_reg;

    logic              capture_en, shift_en, format_en;
    logic              last_bit;
    logic              neg_in, ovf_in;
    logic [DATA_W-1:0] mag_in;
    logic [31:0]       mag_ext;
    logic [31:0]       bcd_adj;
    logic [31:0]       code_next;
    logic [7:0]        blank_w, dash_w;

    // State register
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign last_bit = (cnt_reg == CNT_W'(DATA_W - 1));

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = FORMAT;
            FORMAT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        capture_en = 1'b0;
        shift_en   = 1'b0;
        format_en  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE:    capture_en = start;
            SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
            end
            FORMAT: begin
                format_en = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Unary minus in DATA_W bits maps the most-negative input to its true magnitude.
    assign neg_in  = SIGNED & data_in[DATA_W-1];
    assign mag_in  = neg_in ? -data_in : data_in;
    assign mag_ext = {{(32-DATA_W){1'b0}}, mag_in};
    assign ovf_in  = neg_in ? (mag_ext > 32'd9_999_999) : (mag_ext > 32'd99_999_999);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end

        // A digit position is blank when it and everything to its left is zero;
        // the dash goes in the rightmost blank position.
        for (gi = 0; gi < 8; gi++) begin : g_fmt
            if (gi == 0) begin : g_lsd
                assign blank_w[gi] = 1'b0;
                assign dash_w[gi]  = 1'b0;
            end else if (BLANK_LZ) begin : g_blank
                assign blank_w[gi] = (bcd_reg[31:4*gi] == '0);
                assign dash_w[gi]  = blank_w[gi] & ~blank_w[gi-1];
            end else begin : g_pad
                assign blank_w[gi] = 1'b0;
                assign dash_w[gi]  = (gi == 7);
            end
            assign code_next[4*gi +: 4] = ovf_reg                  ? CODE_DASH  :
                                          (neg_reg && dash_w[gi])  ? CODE_DASH  :
                                          blank_w[gi]              ? CODE_BLANK :
                                                                     bcd_reg[4*gi +: 4];
        end
    endgenerate

    // Datapath
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            mag_reg  <= '0;
            bcd_reg  <= '0;
            neg_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
            done_reg <= 1'b0;
            disp_reg <= DISP_RST;
        end else begin
            done_reg <= format_en;
            if (capture_en) begin
                cnt_reg <= '0;
                mag_reg <= mag_in;
                bcd_reg <= '0;
                neg_reg <= neg_in;
                ovf_reg <= ovf_in;
            end else if (shift_en) begin
                {bcd_reg, mag_reg} <= {bcd_adj, mag_reg} << 1;
                cnt_reg            <= cnt_reg + 1'b1;
            end
            if (format_en) begin
                disp_reg <= code_next;
            end
        end
    end

    assign done  = done_reg;
    assign bit_7 = disp_reg[31:28];
    assign bit_6 = disp_reg[27:24];
    assign bit_5 = disp_reg[23:20];
    assign bit_4 = disp_reg[19:16];
    assign bit_3 = disp_reg[15:12];
    assign bit_2 = disp_reg[11:8];
    assign bit_1 = disp_reg[7:4];
    assign bit_0 = disp_reg[3:0];

endmodule

// File: tb/tb_bin_to_disp_digits.sv
// Bench for bin_to_disp_digits: three variants (unsigned/blanked, unsigned/padded,
// signed/blanked) share one stimulus and are checked against a decimal reference model.
module tb_bin_to_disp_digits;
    logic        sclk;
    logic        rst;
    logic        start;
    logic [26:0] data_in;
    logic        busy_d, busy_n, busy_s;
    logic        done_d, done_n, done_s;
    logic [3:0]  cd [8];
    logic [3:0]  cn [8];
    logic [3:0]  cs [8];
    logic [31:0] obs_d, obs_n, obs_s;
    logic [26:0] hist [100];

    int n_tests = 0;
    int n_fail  = 0;

    initial sclk = 1'b0;
    always #10 sclk = ~sclk;

    bin_to_disp_digits #(.DATA_W(27), .SIGNED(1'b0), .BLANK_LZ(1'b1)) u_dut_d (
        .sclk(sclk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy_d), .done(done_d),
        .bit_7(cd[7]), .bit_6(cd[6]), .bit_5(cd[5]), .bit_4(cd[4]),
        .bit_3(cd[3]), .bit_2(cd[2]), .bit_1(cd[1]), .bit_0(cd[0])
    );

    bin_to_disp_digits #(.DATA_W(27), .SIGNED(1'b0), .BLANK_LZ(1'b0)) u_dut_n (
        .sclk(sclk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy_n), .done(done_n),
        .bit_7(cn[7]), .bit_6(cn[6]), .bit_5(cn[5]), .bit_4(cn[4]),
        .bit_3(cn[3]), .bit_2(cn[2]), .bit_1(cn[1]), .bit_0(cn[0])
    );

    bin_to_disp_digits #(.DATA_W(27), .SIGNED(1'b1), .BLANK_LZ(1'b1)) u_dut_s (
        .sclk(sclk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy_s), .done(done_s),
        .bit_7(cs[7]), .bit_6(cs[6]), .bit_5(cs[5]), .bit_4(cs[4]),
        .bit_3(cs[3]), .bit_2(cs[2]), .bit_1(cs[1]), .bit_0(cs[0])
    );

    assign obs_d = {cd[7], cd[6], cd[5], cd[4], cd[3], cd[2], cd[1], cd[0]};
    assign obs_n = {cn[7], cn[6], cn[5], cn[4], cn[3], cn[2], cn[1], cn[0]};
    assign obs_s = {cs[7], cs[6], cs[5], cs[4], cs[3], cs[2], cs[1], cs[0]};

    // Expected display word {bit_7..bit_0} derived from the value's decimal digits.
    function automatic logic [31:0] model(input logic [26:0] v, input bit sgn, input bit blz);
        longint      m   = longint'(v);
        bit          neg = sgn && v[26];
        logic [31:0] r   = '0;
        int          nd  = 1;
        longint      t;
        if (neg) m = 134217728 - m;
        if ((neg && m > 9999999) || m > 99999999) return {8{4'hB}};
        for (longint q = m; q >= 10; q = q / 10) nd++;
        t = m;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] c;
            c = 4'(t % 10);
            t = t / 10;
            if (blz && i >= nd) c = 4'd10;
            if (neg && ((blz && i == nd) || (!blz && i == 7))) c = 4'd11;
            r[4*i +: 4] = c;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One conversion with stray start pulses mid-shift and in the FORMAT cycle.
    task automatic run_conv(input logic [26:0] v);
        logic [31:0] prev_d, prev_n, prev_s;
        int k;
        bit held;
        @(negedge sclk);
        prev_d  = obs_d;
        prev_n  = obs_n;
        prev_s  = obs_s;
        data_in = v;
        start   = 1'b1;
        @(posedge sclk);
        #1;
        start   = 1'b0;
        data_in = 27'($urandom);
        check("busy_after_start", 32'(busy_d), 32'd1);
        k    = 0;
        held = 1'b1;
        while (!done_d && k < 40) begin
            if (obs_d !== prev_d || obs_n !== prev_n || obs_s !== prev_s) held = 1'b0;
            start = (k == 5 || k == 27);
            if (start) data_in = 27'($urandom);
            @(posedge sclk);
            #1;
            k++;
        end
        start = 1'b0;
        check("latency", 32'(k), 32'd28);
        check("outputs_held", 32'(held), 32'd1);
        check("done_all", {29'd0, done_d, done_n, done_s}, 32'd7);
        check("busy_at_done", 32'(busy_d), 32'd0);
        check("codes_lz", obs_d, model(v, 1'b0, 1'b1));
        check("codes_pad", obs_n, model(v, 1'b0, 1'b0));
        check("codes_signed", obs_s, model(v, 1'b1, 1'b1));
        $display("[TB] value=%0d lz=%h pad=%h signed=%h", v, obs_d, obs_n, obs_s);
        @(posedge sclk);
        #1;
        check("done_one_cycle", 32'(done_d), 32'd0);
        check("no_queued_start", 32'(busy_d), 32'd0);
    endtask

    initial begin
        int n_done;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(posedge sclk);
        #1;
        check("reset_busy", {29'd0, busy_d, busy_n, busy_s}, 32'd0);
        check("reset_done", {29'd0, done_d, done_n, done_s}, 32'd0);
        check("reset_lz", obs_d, 32'hAAAA_AAA0);
        check("reset_pad", obs_n, 32'h0000_0000);
        check("reset_signed", obs_s, 32'hAAAA_AAA0);
        @(negedge sclk);
        rst = 1'b0;

        run_conv(27'd12_345_678);
        check("ex_12345678", obs_d, 32'h1234_5678);
        run_conv(27'd905);
        check("ex_905_lz", obs_d, 32'hAAAA_A905);
        check("ex_905_pad", obs_n, 32'h0000_0905);
        run_conv(27'(-42));
        check("ex_neg42", obs_s, 32'hAAAA_AB42);
        run_conv(27'(-9_999_999));
        check("ex_neg9999999", obs_s, 32'hB999_9999);
        run_conv(27'd100_000_000);
        check("ex_ovf_unsigned", obs_d, 32'hBBBB_BBBB);
        run_conv(27'h400_0000);
        check("ex_ovf_mostneg", obs_s, 32'hBBBB_BBBB);
        run_conv(27'd0);
        check("ex_zero", obs_d, 32'hAAAA_AAA0);
        run_conv(27'd99_999_999);
        run_conv(27'(-10_000_000));

        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) run_conv(27'($urandom_range(0, 99_999)));
            else            run_conv(27'($urandom));
        end

        // Reset in the middle of a conversion
        @(negedge sclk);
        data_in = 27'd12_345_678;
        start   = 1'b1;
        @(posedge sclk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge sclk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {29'd0, busy_d, busy_n, busy_s}, 32'd0);
        check("abort_done", {29'd0, done_d, done_n, done_s}, 32'd0);
        check("abort_lz", obs_d, 32'hAAAA_AAA0);
        check("abort_pad", obs_n, 32'h0000_0000);
        @(negedge sclk);
        rst    = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge sclk);
            #1;
            if (done_d || done_n || done_s) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_hold_lz", obs_d, 32'hAAAA_AAA0);

        // start held high with new data every cycle: accepted on edges 0, 29, 58, 87
        n_done = 0;
        for (int e = 0; e < 100; e++) begin
            @(negedge sclk);
            hist[e] = (e % 3 == 0) ? 27'($urandom) : 27'($urandom_range(0, 9_999_999));
            data_in = hist[e];
            start   = 1'b1;
            @(posedge sclk);
            #1;
            if (done_d) begin
                n_done++;
                check("b2b_done_edge", 32'(e >= 28 && (e - 28) % 29 == 0), 32'd1);
                if (e >= 28) begin
                    check("b2b_lz", obs_d, model(hist[e-28], 1'b0, 1'b1));
                    check("b2b_signed", obs_s, model(hist[e-28], 1'b1, 1'b1));
                    $display("[TB] b2b edge=%0d value=%0d lz=%h", e, hist[e-28], obs_d);
                end
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(n_done), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
